// File: rtl/core_pkg.sv
// Shared RV32I constants: opcodes, funct3 codes, CSR addresses, ALU ops.
// Also holds the ALU operation decoder used by core.
package core_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_PRIV = 3'b000;
   localparam logic [1:0] CSR_RW  = 2'b01;
   localparam logic [1:0] CSR_RS  = 2'b10;
   localparam logic [1:0] CSR_RC  = 2'b11;

   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MHARTID = 12'hF14;

   localparam logic [11:0] SYS_ECALL = 12'h000;
   localparam logic [11:0] SYS_MRET  = 12'h302;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   function automatic alu_op_e alu_dec(input logic [2:0] f3,
                                       input logic       alt);
      alu_op_e op;
      unique case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/core_memory.sv
// Unified byte-addressed little-endian memory, one fetch and one data port.
// Every lane computes its own wrapped address so misaligned accesses just work.
module core_memory #(
   parameter int MEM_BYTES = 65536
) (
   input  logic        clk_i,
   input  logic [31:0] faddr_i,
   output logic [31:0] fdata_o,
   input  logic [31:0] daddr_i,
   output logic [31:0] rdata_o,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  be_i,
   input  logic        we_i
);

   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0] m [0:MEM_BYTES-1];

   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [AW-1:0] fa;
      logic [AW-1:0] da;
      assign fa = faddr_i[AW-1:0] + AW'(k);
      assign da = daddr_i[AW-1:0] + AW'(k);
      assign fdata_o[8*k +: 8] = m[fa];
      assign rdata_o[8*k +: 8] = m[da];
   end

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k])
               m[daddr_i[AW-1:0] + AW'(k)] <= wdata_i[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/core.sv
// Single-cycle RV32I machine-mode core: fetch, decode, execute
// and commit of one instruction per clock.
module core
   import core_pkg::*;
#(
   parameter int          MEM_BYTES = 65536,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input logic clk,
   input logic rst
);

   logic [31:0] pc;
   logic [31:0] rs  [0:31];
   logic [31:0] csr [0:4095];

   logic [31:0] instr;
   logic [31:0] daddr;
   logic [31:0] rdata;
   logic [3:0]  be;
   logic        mem_we;

   logic [6:0]  opc;
   logic [4:0]  rd;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [2:0]  f3;
   logic [11:0] csr_a;

   assign opc   = instr[6:0];
   assign rd    = instr[11:7];
   assign f3    = instr[14:12];
   assign ra1   = instr[19:15];
   assign ra2   = instr[24:20];
   assign csr_a = instr[31:20];

   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};

   logic is_lui, is_auipc, is_jal, is_jalr, is_br;
   logic is_ld, is_st, is_imm, is_reg, is_fence, is_sys;

   assign is_lui   = opc == OP_LUI;
   assign is_auipc = opc == OP_AUIPC;
   assign is_jal   = opc == OP_JAL;
   assign is_jalr  = opc == OP_JALR;
   assign is_br    = opc == OP_BRANCH;
   assign is_ld    = opc == OP_LOAD;
   assign is_st    = opc == OP_STORE;
   assign is_imm   = opc == OP_IMM;
   assign is_reg   = opc == OP_REG;
   assign is_fence = opc == OP_FENCE;
   assign is_sys   = opc == OP_SYSTEM;

   logic [31:0] r1, r2;

   assign r1 = (ra1 == 5'd0) ? 32'd0 : rs[ra1];
   assign r2 = (ra2 == 5'd0) ? 32'd0 : rs[ra2];

   alu_op_e     alu_op;
   logic [31:0] alu_b;
   logic [31:0] alu_y;

   assign alu_op = alu_dec(f3, instr[30] & (is_reg | (f3 == F3_SR)));
   assign alu_b  = is_reg ? r2 : imm_i;

   always_comb begin
      alu_y = 32'd0;
      unique case (alu_op)
         ALU_ADD:  alu_y = r1 + alu_b;
         ALU_SUB:  alu_y = r1 - alu_b;
         ALU_SLL:  alu_y = r1 << alu_b[4:0];
         ALU_SLT:  alu_y = {31'd0, $signed(r1) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'd0, r1 < alu_b};
         ALU_XOR:  alu_y = r1 ^ alu_b;
         ALU_SRL:  alu_y = r1 >> alu_b[4:0];
         ALU_SRA:  alu_y = $signed(r1) >>> alu_b[4:0];
         ALU_OR:   alu_y = r1 | alu_b;
         ALU_AND:  alu_y = r1 & alu_b;
         default:  alu_y = 32'd0;
      endcase
   end

   logic take;

   always_comb begin
      unique case (f3)
         F3_BEQ:  take = r1 == r2;
         F3_BNE:  take = r1 != r2;
         F3_BLT:  take = $signed(r1) < $signed(r2);
         F3_BGE:  take = $signed(r1) >= $signed(r2);
         F3_BLTU: take = r1 < r2;
         F3_BGEU: take = r1 >= r2;
         default: take = 1'b0;
      endcase
   end

   assign daddr = r1 + (is_st ? imm_s : imm_i);

   logic [31:0] ld_val;

   always_comb begin
      unique case (f3)
         F3_B:    ld_val = {{24{rdata[7]}}, rdata[7:0]};
         F3_H:    ld_val = {{16{rdata[15]}}, rdata[15:0]};
         F3_BU:   ld_val = {24'd0, rdata[7:0]};
         F3_HU:   ld_val = {16'd0, rdata[15:0]};
         default: ld_val = rdata;
      endcase
      unique case (f3)
         F3_B:    be = 4'b0001;
         F3_H:    be = 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   logic [31:0] csr_old;
   logic [31:0] csr_src;

   assign csr_old = (csr_a == CSR_MHARTID) ? 32'd0 : csr[csr_a];
   assign csr_src = f3[2] ? {27'd0, ra1} : r1;

   logic [31:0] pc_d;
   logic [31:0] rd_val;
   logic [31:0] csr_wd;
   logic        rd_we;
   logic        csr_we;
   logic        trap;

   always_comb begin
      pc_d   = pc + 32'd4;
      rd_we  = 1'b0;
      rd_val = alu_y;
      csr_we = 1'b0;
      csr_wd = csr_old;
      trap   = 1'b0;
      mem_we = 1'b0;
      unique case (1'b1)
         is_lui: begin
            rd_we  = 1'b1;
            rd_val = imm_u;
         end
         is_auipc: begin
            rd_we  = 1'b1;
            rd_val = pc + imm_u;
         end
         is_jal: begin
            rd_we  = 1'b1;
            rd_val = pc + 32'd4;
            pc_d   = pc + imm_j;
         end
         is_jalr: begin
            rd_we  = 1'b1;
            rd_val = pc + 32'd4;
            pc_d   = (r1 + imm_i) & ~32'd1;
         end
         is_br: begin
            if (take)
               pc_d = pc + imm_b;
         end
         is_ld: begin
            rd_we  = 1'b1;
            rd_val = ld_val;
         end
         is_st:  mem_we = ~rst;
         is_imm: rd_we  = 1'b1;
         is_reg: rd_we  = 1'b1;
         is_fence: ;
         is_sys: begin
            if (f3 == F3_PRIV) begin
               if (csr_a == SYS_ECALL) begin
                  trap = 1'b1;
                  pc_d = csr[CSR_MTVEC];
               end else if (csr_a == SYS_MRET) begin
                  pc_d = csr[CSR_MEPC];
               end
            end else if (f3[1:0] != 2'b00) begin
               rd_we  = 1'b1;
               rd_val = csr_old;
               csr_we = (f3[1:0] == CSR_RW) || (ra1 != 5'd0);
               unique case (f3[1:0])
                  CSR_RS:  csr_wd = csr_old | csr_src;
                  CSR_RC:  csr_wd = csr_old & ~csr_src;
                  default: csr_wd = csr_src;
               endcase
            end
         end
         default: ;
      endcase
   end

   // mhartid is hardwired; drop writes so the array copy stays zero too
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++)
            rs[i] <= 32'd0;
         for (int i = 0; i < 4096; i++)
            csr[i] <= 32'd0;
      end else begin
         pc <= pc_d;
         if (rd_we && rd != 5'd0)
            rs[rd] <= rd_val;
         if (csr_we && csr_a != CSR_MHARTID)
            csr[csr_a] <= csr_wd;
         if (trap) begin
            csr[CSR_MEPC]   <= pc;
            csr[CSR_MCAUSE] <= 32'd11;
         end
      end
   end

   core_memory #(
      .MEM_BYTES(MEM_BYTES)
   ) memory (
      .clk_i  (clk),
      .faddr_i(pc),
      .fdata_o(instr),
      .daddr_i(daddr),
      .rdata_o(rdata),
      .wdata_i(r2),
      .be_i   (be),
      .we_i   (mem_we)
   );

endmodule

// File: tb/tb_core.sv
// Directed-program bench for core: expectations are queued per retired
// instruction count and checked by an independent monitor.
module tb_core;

   logic clk;
   logic rst;

   core dut (
      .clk(clk),
      .rst(rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          kind;
      int          idx;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   checks;
   int   errors;

   localparam logic [6:0] IMM = 7'b0010011;
   localparam logic [6:0] REG = 7'b0110011;
   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] SYS = 7'b1110011;

   function automatic logic [31:0] i_t(int imm, int r1, int f3,
                                       int rd, logic [6:0] op);
      logic [11:0] im;
      im = imm[11:0];
      return {im, 5'(r1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] r_t(int f7, int r2, int r1,
                                       int f3, int rd);
      return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), REG};
   endfunction

   function automatic logic [31:0] s_t(int imm, int r2, int r1, int f3);
      logic [11:0] im;
      im = imm[11:0];
      return {im[11:5], 5'(r2), 5'(r1), 3'(f3), im[4:0], ST};
   endfunction

   function automatic logic [31:0] b_t(int imm, int r2, int r1, int f3);
      logic [12:0] im;
      im = imm[12:0];
      return {im[12], im[10:5], 5'(r2), 5'(r1), 3'(f3),
              im[4:1], im[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] u_t(int imm, int rd, logic [6:0] op);
      logic [19:0] im;
      im = imm[19:0];
      return {im, 5'(rd), op};
   endfunction

   function automatic logic [31:0] j_t(int imm, int rd);
      logic [20:0] im;
      im = imm[20:0];
      return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
   endfunction

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   exp_t        e;
   logic [31:0] act;

   always @(negedge clk) begin
      if (!rst) begin
         while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0:       act = dut.pc;
               1:       act = dut.rs[e.idx[4:0]];
               default: act = dut.csr[e.idx[11:0]];
            endcase
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s at cycle %0d: got %h expected %h",
                        e.name, e.cyc, act, e.exp);
            end
         end
      end
   end

   task automatic ex(int c, int k, int i, logic [31:0] v, string n);
      exp_t t;
      t.cyc  = c;
      t.kind = k;
      t.idx  = i;
      t.exp  = v;
      t.name = n;
      sb.push_back(t);
   endtask

   task automatic put(int a, logic [31:0] w);
      for (int k = 0; k < 4; k++)
         dut.memory.m[16'(a + k)] = w[8*k +: 8];
   endtask

   task automatic begin_prog();
      rst = 1'b1;
      for (int a = 0; a < 65536; a++)
         dut.memory.m[a] = 8'h00;
   endtask

   task automatic run_prog(string tag);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 300 && sb.size() > 0; i++)
         @(posedge clk);
      if (sb.size() > 0) begin
         $display("FAIL %s timeout: %0d checks pending, got none expected 0",
                  tag, sb.size());
         errors += sb.size();
         sb.delete();
      end
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      checks = 0;
      errors = 0;

      // ALU
      begin_prog();
      put(0,  i_t(12'h0f0, 0, 0, 1, IMM));
      put(4,  i_t(-241, 1, 4, 2, IMM));
      put(8,  i_t(1, 1, 4, 0, IMM));
      put(12, u_t(20'h80000, 3, 7'b0110111));
      put(16, i_t(12'h404, 3, 5, 4, IMM));
      put(20, i_t(31, 3, 5, 5, IMM));
      put(24, r_t(7'h20, 1, 0, 0, 6));
      put(28, r_t(0, 1, 6, 2, 7));
      put(32, r_t(0, 6, 1, 3, 8));
      put(36, u_t(1, 9, 7'b0010111));
      put(40, r_t(0, 2, 1, 0, 10));
      put(44, i_t(33, 0, 0, 11, IMM));
      put(48, r_t(0, 11, 1, 1, 12));
      put(52, r_t(7'h20, 11, 3, 5, 13));
      ex(0,  0, 0,  32'h0,        "reset_pc");
      ex(1,  1, 1,  32'h000000F0, "addi");
      ex(2,  1, 2,  32'hFFFFFFFF, "xori_neg");
      ex(3,  1, 0,  32'h0,        "x0_write");
      ex(4,  1, 3,  32'h80000000, "lui");
      ex(5,  1, 4,  32'hF8000000, "srai");
      ex(6,  1, 5,  32'h00000001, "srli");
      ex(7,  1, 6,  32'hFFFFFF10, "sub");
      ex(8,  1, 7,  32'h00000001, "slt");
      ex(9,  1, 8,  32'h00000001, "sltu");
      ex(10, 1, 9,  32'h00001024, "auipc");
      ex(11, 1, 10, 32'h000000EF, "add_wrap");
      ex(13, 1, 12, 32'h000001E0, "sll_amt5");
      ex(14, 1, 13, 32'hC0000000, "sra_amt5");
      ex(14, 0, 0,  32'd56,       "pc_seq");
      ex(16, 0, 0,  32'd64,       "illegal_nop");
      run_prog("alu");

      // loads/stores
      begin_prog();
      put(16'hFFFC, 32'hDEADBEEF);
      put(0,  u_t(20'h80FF8, 1, 7'b0110111));
      put(4,  i_t(-255, 1, 0, 1, IMM));
      put(8,  s_t(12'h100, 1, 0, 2));
      put(12, i_t(12'h100, 0, 0, 2, LD));
      put(16, i_t(12'h103, 0, 0, 3, LD));
      put(20, i_t(12'h102, 0, 5, 4, LD));
      put(24, i_t(12'h100, 0, 2, 5, LD));
      put(28, i_t(12'h101, 0, 1, 6, LD));
      put(32, s_t(12'h104, 1, 0, 0));
      put(36, i_t(12'h104, 0, 4, 7, LD));
      put(40, s_t(12'h106, 1, 0, 1));
      put(44, i_t(12'h104, 0, 2, 8, LD));
      put(48, i_t(-4, 0, 2, 9, LD));
      put(52, i_t(-2, 0, 2, 10, LD));
      ex(0,  1, 1,  32'h0,        "reset_x1");
      ex(0,  1, 13, 32'h0,        "reset_x13");
      ex(2,  1, 1,  32'h80FF7F01, "lui_addi");
      ex(4,  1, 2,  32'h00000001, "lb");
      ex(5,  1, 3,  32'hFFFFFF80, "lb_sign");
      ex(6,  1, 4,  32'h000080FF, "lhu");
      ex(7,  1, 5,  32'h80FF7F01, "lw");
      ex(8,  1, 6,  32'hFFFFFF7F, "lh_misal");
      ex(10, 1, 7,  32'h00000001, "sb_lbu");
      ex(12, 1, 8,  32'h7F010001, "sh_lw");
      ex(13, 1, 9,  32'hDEADBEEF, "lw_top");
      ex(14, 1, 10, 32'h80B7DEAD, "lw_wrap");
      run_prog("mem");

      // control flow
      begin_prog();
      put(16'h00, j_t(32'h20, 0));
      put(16'h18, i_t(5, 0, 0, 2, IMM));
      put(16'h1C, i_t(0, 0, 0, 0, IMM));
      put(16'h20, b_t(-8, 0, 2, 0));
      put(16'h24, b_t(12, 0, 2, 1));
      put(16'h30, j_t(12, 1));
      put(16'h3C, i_t(12'h041, 0, 0, 3, IMM));
      put(16'h40, i_t(0, 3, 0, 3, 7'b1100111));
      put(16'h44, i_t(-1, 0, 0, 4, IMM));
      put(16'h48, b_t(8, 4, 0, 6));
      put(16'h50, b_t(8, 4, 0, 4));
      put(16'h54, b_t(8, 4, 0, 5));
      put(16'h5C, b_t(8, 4, 0, 7));
      ex(1,  0, 0, 32'h20, "jal_fwd");
      ex(2,  0, 0, 32'h18, "beq_taken");
      ex(3,  1, 2, 32'h5,  "x2_set");
      ex(5,  0, 0, 32'h24, "beq_not");
      ex(6,  0, 0, 32'h30, "bne_taken");
      ex(7,  0, 0, 32'h3C, "jal_pc");
      ex(7,  1, 1, 32'h34, "jal_link");
      ex(9,  0, 0, 32'h40, "jalr_odd");
      ex(9,  1, 3, 32'h44, "jalr_rd_rs1");
      ex(10, 0, 0, 32'h44, "jalr_link_tgt");
      ex(12, 0, 0, 32'h50, "bltu_taken");
      ex(13, 0, 0, 32'h54, "blt_not");
      ex(14, 0, 0, 32'h5C, "bge_taken");
      ex(15, 0, 0, 32'h60, "bgeu_not");
      run_prog("ctl");

      // CSR and trap
      begin_prog();
      put(16'h00, j_t(32'h40, 0));
      put(16'h40, i_t(12'h305, 4, 5, 7, SYS));
      put(16'h44, i_t(12'hF14, 7, 5, 0, SYS));
      put(16'h48, i_t(12'hF14, 0, 2, 8, SYS));
      put(16'h4C, i_t(12'h305, 0, 3, 9, SYS));
      put(16'h50, j_t(32'h30, 0));
      put(16'h80, 32'h00000073);
      put(16'h04, i_t(12'h342, 0, 2, 5, SYS));
      put(16'h08, i_t(12'h341, 0, 2, 6, SYS));
      put(16'h0C, 32'h30200073);
      ex(2,  2, 12'h305, 32'h4,  "csrrwi");
      ex(4,  1, 8,       32'h0,  "mhartid_rd");
      ex(4,  2, 12'hF14, 32'h0,  "mhartid_arr");
      ex(5,  1, 9,       32'h4,  "csrrc_x0_old");
      ex(5,  2, 12'h305, 32'h4,  "csrrc_x0_nowr");
      ex(6,  0, 0,       32'h80, "to_ecall");
      ex(7,  0, 0,       32'h4,  "ecall_pc");
      ex(7,  2, 12'h341, 32'h80, "mepc");
      ex(7,  2, 12'h342, 32'd11, "mcause");
      ex(8,  1, 5,       32'd11, "csrr_mcause");
      ex(9,  1, 6,       32'h80, "csrr_mepc");
      ex(10, 0, 0,       32'h80, "mret_pc");
      run_prog("trap");

      // store then fetch of the stored word
      begin_prog();
      put(0,  u_t(20'h05500, 1, 7'b0110111));
      put(4,  i_t(12'h113, 1, 0, 1, IMM));
      put(8,  s_t(12, 1, 0, 2));
      put(12, i_t(0, 0, 0, 0, IMM));
      ex(0, 2, 12'h341, 32'h0,  "reset_mepc");
      ex(3, 0, 0,       32'hC,  "pc_smc");
      ex(4, 1, 2,       32'h55, "fetch_new");
      run_prog("smc");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
